mips_run_ctrl: RTL

//  Run controller that sequences the single-cycle MIPS core (mips_scp) in four

---
 rtl/mips_pkg.sv | 19 +
 rtl/mips_halt_detect.sv | 25 ++
 rtl/mips_run_ctrl.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared opcodes, FSM state encoding and run status codes for the MIPS run controller.
package mips_pkg;

    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_BEQ = 6'b000100;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD      = 3'd1,
        S_RESET_CPU = 3'd2,
        S_RUN       = 3'd3,
        S_DONE      = 3'd4
    } state_t;

    localparam logic [1:0] ST_NONE = 2'b00;
    localparam logic [1:0] ST_HALT = 2'b01;
    localparam logic [1:0] ST_TMO  = 2'b10;

endpackage

// File: rtl/mips_halt_detect.sv
// Combinational self-loop decoder: flags a j-to-self or a beq rs==rt with offset -1.
module mips_halt_detect
    import mips_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] instr,
    output logic        halt_hit_c
);

    logic [31:0] j_target;

    // Either loop form keeps the PC fixed forever, so the program is finished.
    always_comb begin
        j_target   = {pc[31:28], instr[25:0], 2'b00};
        halt_hit_c = 1'b0;
        if ((instr[31:26] == OP_J) && (j_target == pc)) begin
            halt_hit_c = 1'b1;
        end
        if ((instr[31:26] == OP_BEQ) && (instr[25:21] == instr[20:16]) &&
            (instr[15:0] == 16'hFFFF)) begin
            halt_hit_c = 1'b1;
        end
    end

endmodule

// File: rtl/mips_run_ctrl.sv
// Run controller for the single-cycle MIPS core: load IRAM, hold reset, run, done.
// Optional build macro MIPS_RUN_CTRL_SINGLE_STEP_EN adds pause/step inputs for
// single-stepping the core while in RUN.
module mips_run_ctrl
    import mips_pkg::*;
#(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned CYC_W   = 16,
    parameter int unsigned RST_CYC = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CYC_W-1:0]  max_cycles,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [31:0]       ld_data,
    input  logic              ld_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [31:0]       imem_wdata,
    input  logic [31:0]       cpu_pc,
    input  logic [31:0]       cpu_instr,
    output logic              cpu_rst,
    output logic              cpu_en,
    output logic              busy,
    output logic              done,
    output logic [1:0]        status,
`ifdef MIPS_RUN_CTRL_SINGLE_STEP_EN
    input  logic              pause,
    input  logic              step,
`endif
    output logic [CYC_W-1:0]  cycle_count
);

    localparam int unsigned       RC_W      = $clog2(RST_CYC + 1);
    localparam logic [ADDR_W-1:0] WADDR_MAX = '1;
    localparam logic [CYC_W-1:0]  CYC_MAX   = '1;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] waddr_q;
    logic [CYC_W-1:0]  max_q;
    logic [CYC_W-1:0]  cycle_q;
    logic [RC_W-1:0]   rst_cnt_q;
    logic [1:0]        status_q;
    logic              we_q;
    logic [ADDR_W-1:0] imem_waddr_q;
    logic [31:0]       wdata_q;
    logic              halt_hit_c;
    logic              timeout_c;
    logic              start_acc_c;
    logic              hs_c;
    logic              run_ok_c;
`ifdef MIPS_RUN_CTRL_SINGLE_STEP_EN
    logic              step_q;
    logic              step_rise_c;
`endif

    mips_halt_detect u_halt (
        .pc         (cpu_pc),
        .instr      (cpu_instr),
        .halt_hit_c (halt_hit_c)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus control strobes decoded straight from the state register.
    always_comb begin
        state_d     = state_q;
        start_acc_c = 1'b0;
        hs_c        = 1'b0;
        run_ok_c    = 1'b0;
        ld_ready    = 1'b0;
        cpu_rst     = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        timeout_c   = (max_q != '0) && (cycle_q == max_q);
        case (state_q)
            S_IDLE: begin
                cpu_rst = 1'b1;
                if (start) begin
                    start_acc_c = 1'b1;
                    state_d     = S_LOAD;
                end
            end
            S_LOAD: begin
                cpu_rst  = 1'b1;
                busy     = 1'b1;
                ld_ready = 1'b1;
                hs_c     = ld_valid;
                // Stopping at the top address keeps waddr from wrapping onto word 0.
                if (ld_valid && (ld_last || (waddr_q == WADDR_MAX))) begin
                    state_d = S_RESET_CPU;
                end
            end
            S_RESET_CPU: begin
                cpu_rst = 1'b1;
                busy    = 1'b1;
                if (rst_cnt_q == RC_W'(RST_CYC - 1)) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                busy     = 1'b1;
                run_ok_c = !halt_hit_c && !timeout_c;
                if (halt_hit_c || timeout_c) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done = 1'b1;
                if (start) begin
                    start_acc_c = 1'b1;
                    state_d     = S_LOAD;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
`ifdef MIPS_RUN_CTRL_SINGLE_STEP_EN
        step_rise_c = step && !step_q;
        cpu_en      = run_ok_c && (!pause || step_rise_c);
`else
        cpu_en      = run_ok_c;
`endif
    end

    // Load address, IRAM write register, run limit, reset timer, cycle counter, status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            waddr_q      <= '0;
            max_q        <= '0;
            cycle_q      <= '0;
            rst_cnt_q    <= '0;
            status_q     <= ST_NONE;
            we_q         <= 1'b0;
            imem_waddr_q <= '0;
            wdata_q      <= '0;
        end else begin
            we_q <= hs_c;
            if (start_acc_c) begin
                max_q    <= max_cycles;
                status_q <= ST_NONE;
                waddr_q  <= '0;
                cycle_q  <= '0;
            end
            if (hs_c) begin
                imem_waddr_q <= waddr_q;
                wdata_q      <= ld_data;
                if (waddr_q != WADDR_MAX) begin
                    waddr_q <= waddr_q + ADDR_W'(1);
                end
            end
            if (state_q == S_LOAD) begin
                rst_cnt_q <= '0;
            end else if (state_q == S_RESET_CPU) begin
                rst_cnt_q <= rst_cnt_q + RC_W'(1);
                cycle_q   <= '0;
            end
            if (cpu_en && (cycle_q != CYC_MAX)) begin
                cycle_q <= cycle_q + CYC_W'(1);
            end
            // Halt takes priority when both terminate the run in the same cycle.
            if (state_q == S_RUN) begin
                if (halt_hit_c) begin
                    status_q <= ST_HALT;
                end else if (timeout_c) begin
                    status_q <= ST_TMO;
                end
            end
        end
    end

`ifdef MIPS_RUN_CTRL_SINGLE_STEP_EN
    // Previous step level for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_q <= 1'b0;
        end else begin
            step_q <= step;
        end
    end
`endif

    assign imem_we     = we_q;
    assign imem_waddr  = imem_waddr_q;
    assign imem_wdata  = wdata_q;
    assign status      = status_q;
    assign cycle_count = cycle_q;

endmodule
